// File: rtl/pool_tile_collector.sv
// Pixel-stream to N x N tile assembler feeding pooling_layer.
// Two ping-pong banks: one fills from the stream while the other waits for the consumer.
module pool_tile_collector #(
   parameter int N      = 4,
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     in_last,
   output logic                     tile_valid,
   input  logic                     tile_ready,
   output logic [N*N*DATA_W-1:0]    tile_data,
   output logic                     err_framing
);

   localparam int                TILE     = N * N;
   localparam int                CNT_W    = $clog2(TILE);
   localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(TILE - 1);

   logic [DATA_W-1:0] r_mem [2][TILE];
   logic [CNT_W-1:0]  r_cnt;
   logic              r_wrBank;
   logic              r_rdBank;
   logic [1:0]        r_full;
   logic              r_err;

   logic              w_inFire;
   logic              w_outFire;
   logic              w_cntWrap;

   assign in_ready    = !r_full[r_wrBank];
   assign tile_valid  = r_full[r_rdBank];
   assign err_framing = r_err;

   assign w_inFire  = in_valid && in_ready;
   assign w_outFire = tile_valid && tile_ready;
   assign w_cntWrap = (r_cnt == LAST_IDX);

   // Element k = i*N+j of the read bank sits at bits [k*DATA_W +: DATA_W].
   always_comb begin
      tile_data = '0;
      for (int k = 0; k < TILE; k++) begin
         tile_data[k*DATA_W +: DATA_W] = r_mem[r_rdBank][k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < TILE; k++) begin
               r_mem[b][k] <= '0;
            end
         end
      end else if (w_inFire) begin
         r_mem[r_wrBank][r_cnt] <= in_data;
      end
   end

   // A full bank is never written, so the drain and fill updates below always hit different bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_wrBank <= 1'b0;
         r_rdBank <= 1'b0;
         r_full   <= 2'b00;
         r_err    <= 1'b0;
      end else begin
         if (w_outFire) begin
            r_full[r_rdBank] <= 1'b0;
            r_rdBank         <= !r_rdBank;
         end
         if (w_inFire) begin
            if (w_cntWrap) begin
               r_cnt            <= '0;
               r_full[r_wrBank] <= 1'b1;
               r_wrBank         <= !r_wrBank;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
            if (in_last != w_cntWrap) begin
               r_err <= 1'b1;
            end
         end
      end
   end

endmodule
